// File: rtl/johnson_phase_monitor_pkg.sv
// Shared types for the Johnson phase monitor: FSM states, step classes and
// the rule that classifies a new legal phase against the previous one.
package johnson_phase_monitor_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_TRACK,
    ST_LOCKED,
    ST_FAULT
  } state_e;

  typedef enum logic [1:0] {
    SC_HOLD,
    SC_STEP,
    SC_RESTART,
    SC_SKIP
  } step_e;

  // A return to phase 0 from the last phase is a normal step, not a restart.
  function automatic step_e classify_step(input int k, input int p, input int phases);
    step_e sc;
    if (k == p)
      sc = SC_HOLD;
    else if (k == ((p == phases - 1) ? 0 : p + 1))
      sc = SC_STEP;
    else if (k == 0)
      sc = SC_RESTART;
    else
      sc = SC_SKIP;
    return sc;
  endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code decoder: maps a WIDTH-bit code to its phase
// index 0..2*WIDTH-1 and flags codes outside the Johnson sequence.
module johnson_code_decode #(
  parameter  int WIDTH   = 8,
  localparam int PHASES  = 2 * WIDTH,
  localparam int PHASE_W = $clog2(PHASES)
) (
  input  logic [WIDTH-1:0]   code,
  output logic               legal,
  output logic [PHASE_W-1:0] phase
);

  // Phases 0..WIDTH fill ones from the LSB; later phases clear them from the LSB.
  function automatic logic [WIDTH-1:0] pattern(input int k);
    logic [WIDTH-1:0] pat;
    for (int i = 0; i < WIDTH; i++)
      pat[i] = (k <= WIDTH) ? (i < k) : (i >= k - WIDTH);
    return pat;
  endfunction

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    legal = 1'b0;
    phase = '0;
    for (int k = 0; k < PHASES; k++) begin
      if (code == pattern(k)) begin
        legal = 1'b1;
        phase = PHASE_W'(k);
      end
    end
  end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Johnson counter health monitor: registers the incoming code, decodes it,
// tracks lock on a clean run, counts revolutions and keeps sticky error flags.
module johnson_phase_monitor
  import johnson_phase_monitor_pkg::*;
#(
  parameter  int WIDTH      = 8,
  parameter  int LOCK_COUNT = 4,
  parameter  int CYC_W      = 8,
  localparam int PHASES     = 2 * WIDTH,
  localparam int PHASE_W    = $clog2(PHASES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   q_in,
  input  logic               clr_err,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_valid,
  output logic               locked,
  output logic               wrap_pulse,
  output logic [CYC_W-1:0]   cycle_count,
  output logic               err_illegal,
  output logic               err_skip
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);

  logic [WIDTH-1:0]   q_reg;
  logic               dec_legal;
  logic [PHASE_W-1:0] dec_phase;
  step_e              step;
  state_e             state;
  logic [RUN_W-1:0]   run;

  johnson_code_decode #(.WIDTH(WIDTH)) u_decode (
    .code  (q_reg),
    .legal (dec_legal),
    .phase (dec_phase)
  );

  always_comb step = classify_step(int'(dec_phase), int'(phase), PHASES);

  assign locked = (state == ST_LOCKED);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; later assignments in the block take priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg       <= '0;
      phase       <= '0;
      phase_valid <= 1'b0;
      wrap_pulse  <= 1'b0;
      cycle_count <= '0;
      err_illegal <= 1'b0;
      err_skip    <= 1'b0;
      state       <= ST_UNLOCKED;
      run         <= '0;
    end else begin
      q_reg       <= q_in;
      phase_valid <= dec_legal;
      wrap_pulse  <= 1'b0;
      if (dec_legal)
        phase <= dec_phase;

      // Clear first so a same-edge new error overrides it.
      if (clr_err) begin
        err_illegal <= 1'b0;
        err_skip    <= 1'b0;
      end
      if (!dec_legal)
        err_illegal <= 1'b1;

      case (state)
        ST_UNLOCKED: begin
          if (dec_legal) begin
            state <= ST_TRACK;
            run   <= '0;
          end
        end
        ST_TRACK: begin
          if (!dec_legal) begin
            state <= ST_UNLOCKED;
          end else begin
            case (step)
              SC_STEP: begin
                run <= run + 1'b1;
                if (run == RUN_W'(LOCK_COUNT - 1))
                  state <= ST_LOCKED;
              end
              SC_HOLD: ;
              default: run <= '0;
            endcase
          end
        end
        ST_LOCKED: begin
          if (!dec_legal) begin
            state <= ST_FAULT;
          end else begin
            case (step)
              SC_STEP: begin
                if (phase == PHASE_W'(PHASES - 1)) begin
                  wrap_pulse <= 1'b1;
                  if (cycle_count != '1)
                    cycle_count <= cycle_count + 1'b1;
                end
              end
              SC_HOLD: ;
              SC_RESTART: begin
                state <= ST_TRACK;
                run   <= '0;
              end
              default: begin
                state    <= ST_FAULT;
                err_skip <= 1'b1;
              end
            endcase
          end
        end
        default: begin
          if (clr_err && dec_legal)
            state <= ST_UNLOCKED;
        end
      endcase
    end
  end

endmodule
